frame_bank_sched: RTL

Stereo frame and descriptor-bank scheduler for the feature pipeline. It detects left/right frame starts from the pixel-valid stream and rotates five descriptor RAM banks: two are written per stereo pair (L, R) and three are read by the matcher (previous R, current-pair R, current-pair L). It generates descriptor write addresses and per-bank descriptor counts, and issues `match_start` to the matcher with bank selects and counts. Sits between the detector/descriptor stage, the bank RAM controller and the match controller.

---
 rtl/fea_sched_pkg.sv | 21 ++
 rtl/bank_cnt_file.sv | 52 +++++
 rtl/frame_bank_sched.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fea_sched_pkg.sv
// Shared definitions for the stereo frame / descriptor-bank scheduler.
//   NUM_BANKS  number of descriptor RAM banks in rotation
//   BANK_W     width of a bank index
//   frame_state_e  frame tracking state (IDLE before the first frame, then L/R)
//   bank_inc   modulo-NUM_BANKS increment of a bank index
package fea_sched_pkg;

    localparam int NUM_BANKS = 5;
    localparam int BANK_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } frame_state_e;

    function automatic logic [BANK_W-1:0] bank_inc(input logic [BANK_W-1:0] b);
        return (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + 1'b1;
    endfunction

endpackage

// File: rtl/bank_cnt_file.sv
// Per-bank descriptor count file: NUM_BANKS registers of ADDR_W bits.
//   clk, rst            clock, asynchronous active-high reset (clears all counts)
//   we, waddr, wdata    single write port
//   raddr_a/b/c         three read addresses
//   rdata_a/b/c         asynchronous read data (0 for an out-of-range address)
module bank_cnt_file
    import fea_sched_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [BANK_W-1:0] waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [BANK_W-1:0] raddr_a,
    input  logic [BANK_W-1:0] raddr_b,
    input  logic [BANK_W-1:0] raddr_c,
    output logic [ADDR_W-1:0] rdata_a,
    output logic [ADDR_W-1:0] rdata_b,
    output logic [ADDR_W-1:0] rdata_c
);

    logic [ADDR_W-1:0] cnt_q [NUM_BANKS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (waddr == BANK_W'(i)) begin
                    cnt_q[i] <= wdata;
                end
            end
        end
    end

    // Compare-based read mux so indices 5..7 cannot reach past the array.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        rdata_c = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (raddr_a == BANK_W'(i)) rdata_a = cnt_q[i];
            if (raddr_b == BANK_W'(i)) rdata_b = cnt_q[i];
            if (raddr_c == BANK_W'(i)) rdata_c = cnt_q[i];
        end
    end

endmodule

// File: rtl/frame_bank_sched.sv
// Stereo frame and descriptor-bank scheduler.
// Detects frame starts on img_din_valid, alternates L/R frames, rotates five
// descriptor banks, generates write strobes/addresses, commits per-bank counts
// and launches the matcher on the start of every L frame once two stereo pairs
// are complete.
//   clk, rst               clock, asynchronous active-high reset
//   img_din_valid          pixel valid (high for a whole frame)
//   feat_valid             one descriptor available this cycle
//   match_done             one-cycle done pulse from the matcher
//   wr_en/wr_bank/wr_addr  descriptor RAM write port (combinational strobe)
//   frame_side             0 = L frame, 1 = R frame
//   match_start            one-cycle matcher start pulse
//   rd_bank_p/r/l, num_*   banks and counts for the matcher (held between starts)
//   match_busy             matcher running
//   ovf, overrun           sticky error flags
//   overrun_cnt            saturating count of skipped matches
module frame_bank_sched
    import fea_sched_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int MAX_DES = 1023,
    parameter int OVR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              img_din_valid,
    input  logic              feat_valid,
    input  logic              match_done,
    output logic              wr_en,
    output logic [BANK_W-1:0] wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              frame_side,
    output logic              match_start,
    output logic [BANK_W-1:0] rd_bank_p,
    output logic [BANK_W-1:0] rd_bank_r,
    output logic [BANK_W-1:0] rd_bank_l,
    output logic [ADDR_W-1:0] num_p,
    output logic [ADDR_W-1:0] num_r,
    output logic [ADDR_W-1:0] num_l,
    output logic              match_busy,
    output logic              ovf,
    output logic              overrun,
    output logic [OVR_W-1:0]  overrun_cnt
);

    frame_state_e      state_q, state_d;
    logic              vld_q;
    logic [BANK_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [BANK_W-1:0] last_l_q, last_l_d;
    logic [BANK_W-1:0] last_r_q, last_r_d;
    logic              pair_seen_q, pair_seen_d;
    logic              busy_q, busy_d;
    logic              start_q;
    logic [BANK_W-1:0] rd_p_q, rd_p_d, rd_r_q, rd_r_d, rd_l_q, rd_l_d;
    logic [ADDR_W-1:0] num_p_q, num_p_d, num_r_q, num_r_d, num_l_q, num_l_d;
    logic              overrun_q, overrun_d;
    logic [OVR_W-1:0]  overrun_cnt_q, overrun_cnt_d;

    logic              sof;
    logic              active;
    logic              accept;
    logic              commit;
    logic [ADDR_W-1:0] commit_val;
    logic              launch_try, busy_after_done, launch, skip;
    logic [ADDR_W-1:0] rdata_p, rdata_r, rdata_l;

    assign sof        = img_din_valid & ~vld_q;
    assign active     = (state_q != IDLE);
    assign accept     = feat_valid & active & (cnt_q < ADDR_W'(MAX_DES));
    // Nothing to commit on the very first sof: no frame was open.
    assign commit     = sof & active;
    // A descriptor in the sof cycle still belongs to the closing frame.
    assign commit_val = cnt_q + ADDR_W'(accept);

    // Launch only at the start of an L frame, once the pair closing now is
    // at least the second complete pair since reset.
    assign launch_try      = sof & (state_q == RIGHT) & pair_seen_q;
    // A done in the launch cycle frees the matcher before the launch decision.
    assign busy_after_done = busy_q & ~match_done;
    assign launch          = launch_try & ~busy_after_done;
    assign skip            = launch_try & busy_after_done;

    bank_cnt_file #(
        .ADDR_W (ADDR_W)
    ) u_cnt_file (
        .clk     (clk),
        .rst     (rst),
        .we      (commit),
        .waddr   (wp_q),
        .wdata   (commit_val),
        .raddr_a (last_r_q),
        .raddr_b (wp_q),
        .raddr_c (last_l_q),
        .rdata_a (rdata_p),
        .rdata_b (rdata_r),
        .rdata_c (rdata_l)
    );

    // ---------------- frame FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- frame FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (sof) begin
            case (state_q)
                IDLE:    state_d = LEFT;
                LEFT:    state_d = RIGHT;
                RIGHT:   state_d = LEFT;
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- frame FSM: outputs ----------------
    always_comb begin
        wr_en      = accept;
        wr_bank    = wp_q;
        wr_addr    = cnt_q;
        frame_side = (state_q == RIGHT);
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        wp_d          = commit ? bank_inc(wp_q) : wp_q;
        cnt_d         = sof ? '0 : cnt_q + ADDR_W'(accept);
        ovf_d         = ovf_q | (feat_valid & active & ~accept);
        last_l_d      = last_l_q;
        last_r_d      = last_r_q;
        pair_seen_d   = pair_seen_q;
        busy_d        = busy_q;
        rd_p_d        = rd_p_q;
        rd_r_d        = rd_r_q;
        rd_l_d        = rd_l_q;
        num_p_d       = num_p_q;
        num_r_d       = num_r_q;
        num_l_d       = num_l_q;
        overrun_d     = overrun_q;
        overrun_cnt_d = overrun_cnt_q;

        if (commit && state_q == LEFT) begin
            last_l_d = wp_q;
        end
        if (commit && state_q == RIGHT) begin
            last_r_d    = wp_q;
            pair_seen_d = 1'b1;
        end

        if (match_done) begin
            busy_d = 1'b0;
        end

        if (launch) begin
            busy_d  = 1'b1;
            // last_r_q has not yet been overwritten, so it is the previous R bank.
            rd_p_d  = last_r_q;
            rd_r_d  = wp_q;
            rd_l_d  = last_l_q;
            // Bypass the count being committed this very cycle.
            num_p_d = (last_r_q == wp_q) ? commit_val : rdata_p;
            num_r_d = commit_val;
            num_l_d = (last_l_q == wp_q) ? commit_val : rdata_l;
        end

        if (skip) begin
            overrun_d = 1'b1;
            if (overrun_cnt_q != '1) begin
                overrun_cnt_d = overrun_cnt_q + 1'b1;
            end
        end
    end

    // rdata_r is the read-before-commit value of the bank being closed; the
    // launch always takes the committed value instead.
    logic unused_rdata_r;
    assign unused_rdata_r = ^rdata_r;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q         <= 1'b0;
            wp_q          <= '0;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            last_l_q      <= '0;
            last_r_q      <= '0;
            pair_seen_q   <= 1'b0;
            busy_q        <= 1'b0;
            start_q       <= 1'b0;
            rd_p_q        <= '0;
            rd_r_q        <= '0;
            rd_l_q        <= '0;
            num_p_q       <= '0;
            num_r_q       <= '0;
            num_l_q       <= '0;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= '0;
        end else begin
            vld_q         <= img_din_valid;
            wp_q          <= wp_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            last_l_q      <= last_l_d;
            last_r_q      <= last_r_d;
            pair_seen_q   <= pair_seen_d;
            busy_q        <= busy_d;
            start_q       <= launch;
            rd_p_q        <= rd_p_d;
            rd_r_q        <= rd_r_d;
            rd_l_q        <= rd_l_d;
            num_p_q       <= num_p_d;
            num_r_q       <= num_r_d;
            num_l_q       <= num_l_d;
            overrun_q     <= overrun_d;
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign match_start = start_q;
    assign rd_bank_p   = rd_p_q;
    assign rd_bank_r   = rd_r_q;
    assign rd_bank_l   = rd_l_q;
    assign num_p       = num_p_q;
    assign num_r       = num_r_q;
    assign num_l       = num_l_q;
    assign match_busy  = busy_q;
    assign ovf         = ovf_q;
    assign overrun     = overrun_q;
    assign overrun_cnt = overrun_cnt_q;

endmodule
